// File: rtl/int_issue_queue_if.sv
// int_issue_queue_if: dispatch, CDB snoop and ready/issue handshake bundle for the integer issue queue
interface int_issue_queue_if #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    logic              dispatch_en;
    logic [3:0]        dispatch_opcode;
    logic [DATA_W-1:0] dispatch_rsdata;
    logic              dispatch_rsvalid;
    logic [TAG_W-1:0]  dispatch_rstag;
    logic [DATA_W-1:0] dispatch_rtdata;
    logic              dispatch_rtvalid;
    logic [TAG_W-1:0]  dispatch_rttag;
    logic [TAG_W-1:0]  dispatch_rdtag;
    logic              queue_full;
    logic [3:0]        queue_count;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tagout;
    logic [DATA_W-1:0] cdb_out;
    logic              flush;
    logic              ready_int;
    logic              issue_int;
    logic [3:0]        issue_opcode;
    logic [DATA_W-1:0] issue_rsdata;
    logic [DATA_W-1:0] issue_rtdata;
    logic [TAG_W-1:0]  issue_rdtag;

    modport master (
        output dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid, dispatch_rstag,
               dispatch_rtdata, dispatch_rtvalid, dispatch_rttag, dispatch_rdtag,
               cdb_valid, cdb_tagout, cdb_out, flush, issue_int,
        input  queue_full, queue_count, ready_int, issue_opcode, issue_rsdata, issue_rtdata, issue_rdtag
    );

    modport slave (
        input  dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid, dispatch_rstag,
               dispatch_rtdata, dispatch_rtvalid, dispatch_rttag, dispatch_rdtag,
               cdb_valid, cdb_tagout, cdb_out, flush, issue_int,
        output queue_full, queue_count, ready_int, issue_opcode, issue_rsdata, issue_rtdata, issue_rdtag
    );
endinterface

// File: rtl/int_issue_queue.sv
// int_issue_queue: collapsing integer reservation queue with CDB wakeup and oldest-ready issue select
module int_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              reset,
    int_issue_queue_if.slave bus
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              v;
        logic [3:0]        op;
        logic [DATA_W-1:0] rs;
        logic              rsv;
        logic [TAG_W-1:0]  rst;
        logic [DATA_W-1:0] rt;
        logic              rtv;
        logic [TAG_W-1:0]  rtt;
        logic [TAG_W-1:0]  rd;
    } entry_t;

    entry_t     ent   [DEPTH];
    entry_t     woken [DEPTH+1];
    entry_t     nxt   [DEPTH];
    entry_t     new_e;
    logic [IW-1:0] sel;
    logic       found;
    logic       grant;
    logic       do_disp;
    logic [3:0] count;
    logic [3:0] wr_idx;
    logic       rs_hit;
    logic       rt_hit;

    always_comb begin
        found = 1'b0;
        sel = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ent[i].v && ent[i].rsv && ent[i].rtv) begin
                found = 1'b1;
                sel = IW'(i);
            end
        end
    end

    assign bus.queue_full   = count == 4'(DEPTH);
    assign bus.queue_count  = count;
    assign bus.ready_int    = found;
    assign bus.issue_opcode = found ? ent[sel].op : '0;
    assign bus.issue_rsdata = found ? ent[sel].rs : '0;
    assign bus.issue_rtdata = found ? ent[sel].rt : '0;
    assign bus.issue_rdtag  = found ? ent[sel].rd : '0;

    assign grant   = bus.issue_int && found;
    assign do_disp = bus.dispatch_en && !bus.queue_full;
    assign wr_idx  = count - {3'b0, grant};
    assign rs_hit  = bus.cdb_valid && !bus.dispatch_rsvalid && bus.dispatch_rstag == bus.cdb_tagout;
    assign rt_hit  = bus.cdb_valid && !bus.dispatch_rtvalid && bus.dispatch_rttag == bus.cdb_tagout;

    always_comb begin
        new_e = '0;
        new_e.v = 1'b1;
        new_e.op = bus.dispatch_opcode;
        new_e.rs = rs_hit ? bus.cdb_out : bus.dispatch_rsdata;
        new_e.rsv = bus.dispatch_rsvalid || rs_hit;
        new_e.rst = bus.dispatch_rstag;
        new_e.rt = rt_hit ? bus.cdb_out : bus.dispatch_rtdata;
        new_e.rtv = bus.dispatch_rtvalid || rt_hit;
        new_e.rtt = bus.dispatch_rttag;
        new_e.rd = bus.dispatch_rdtag;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent[i];
            if (bus.cdb_valid && ent[i].v && !ent[i].rsv && ent[i].rst == bus.cdb_tagout) begin
                woken[i].rs = bus.cdb_out;
                woken[i].rsv = 1'b1;
            end
            if (bus.cdb_valid && ent[i].v && !ent[i].rtv && ent[i].rtt == bus.cdb_tagout) begin
                woken[i].rt = bus.cdb_out;
                woken[i].rtv = 1'b1;
            end
        end
        woken[DEPTH] = '0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = (grant && IW'(i) >= sel) ? woken[i+1] : woken[i];
            if (do_disp && 4'(i) == wr_idx) nxt[i] = new_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            count <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].v <= 1'b0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
            count <= count + {3'b0, do_disp} - {3'b0, grant};
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: directed self-checking bench for int_issue_queue
module tb_int_issue_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    int_issue_queue_if #(.TAG_W(6), .DATA_W(32)) bus ();

    int_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_en = 0;
        bus.dispatch_opcode = 0;
        bus.dispatch_rsdata = 0;
        bus.dispatch_rsvalid = 0;
        bus.dispatch_rstag = 0;
        bus.dispatch_rtdata = 0;
        bus.dispatch_rtvalid = 0;
        bus.dispatch_rttag = 0;
        bus.dispatch_rdtag = 0;
        bus.cdb_valid = 0;
        bus.cdb_tagout = 0;
        bus.cdb_out = 0;
        bus.flush = 0;
        bus.issue_int = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] rs, input logic rsv, input logic [5:0] rstag,
                        input logic [31:0] rt, input logic rtv, input logic [5:0] rttag, input logic [5:0] rd);
        bus.dispatch_en = 1;
        bus.dispatch_opcode = op;
        bus.dispatch_rsdata = rs;
        bus.dispatch_rsvalid = rsv;
        bus.dispatch_rstag = rstag;
        bus.dispatch_rtdata = rt;
        bus.dispatch_rtvalid = rtv;
        bus.dispatch_rttag = rttag;
        bus.dispatch_rdtag = rd;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1;
        bus.cdb_tagout = tag;
        bus.cdb_out = data;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
        n_checks++; if (bus.ready_int !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready_int); end
        n_checks++; if (bus.queue_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.queue_count); end
        n_checks++; if (bus.queue_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.queue_full); end
        n_checks++; if (bus.issue_rsdata !== 32'h0 || bus.issue_rtdata !== 32'h0 || bus.issue_rdtag !== 6'h0 || bus.issue_opcode !== 4'h0)
            begin n_fail++; $display("FAIL reset_issue: got op=%h rs=%h rt=%h rd=%h want all 0", bus.issue_opcode, bus.issue_rsdata, bus.issue_rtdata, bus.issue_rdtag); end
    endtask

    task automatic test_ready_issue();
        disp(4'h2, 32'h5, 1, 0, 32'h7, 1, 0, 6'd9);
        step();
        idle();
        n_checks++; if (bus.ready_int !== 1'b1) begin n_fail++; $display("FAIL ri_ready: got %b want 1", bus.ready_int); end
        n_checks++; if (bus.issue_opcode !== 4'h2) begin n_fail++; $display("FAIL ri_opcode: got %h want 2", bus.issue_opcode); end
        n_checks++; if (bus.issue_rsdata !== 32'h5 || bus.issue_rtdata !== 32'h7) begin n_fail++; $display("FAIL ri_data: got rs=%h rt=%h want 5 7", bus.issue_rsdata, bus.issue_rtdata); end
        n_checks++; if (bus.issue_rdtag !== 6'd9) begin n_fail++; $display("FAIL ri_rdtag: got %0d want 9", bus.issue_rdtag); end
        n_checks++; if (bus.queue_count !== 4'd1) begin n_fail++; $display("FAIL ri_count1: got %0d want 1", bus.queue_count); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.ready_int !== 1'b0) begin n_fail++; $display("FAIL ri_ready_after: got %b want 0", bus.ready_int); end
        n_checks++; if (bus.queue_count !== 4'd0) begin n_fail++; $display("FAIL ri_count0: got %0d want 0", bus.queue_count); end
    endtask

    task automatic test_wakeup();
        disp(4'h1, 32'h0, 0, 6'd12, 32'h1, 1, 0, 6'd20);
        step();
        idle();
        n_checks++; if (bus.ready_int !== 1'b0) begin n_fail++; $display("FAIL wk_pending: got %b want 0", bus.ready_int); end
        cdb(6'd12, 32'hDEAD);
        step();
        idle();
        n_checks++; if (bus.ready_int !== 1'b1) begin n_fail++; $display("FAIL wk_ready: got %b want 1", bus.ready_int); end
        n_checks++; if (bus.issue_rsdata !== 32'hDEAD || bus.issue_rtdata !== 32'h1) begin n_fail++; $display("FAIL wk_data: got rs=%h rt=%h want dead 1", bus.issue_rsdata, bus.issue_rtdata); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.queue_count !== 4'd0) begin n_fail++; $display("FAIL wk_drain: got %0d want 0", bus.queue_count); end
    endtask

    task automatic test_wakeup_both();
        disp(4'h3, 32'h0, 0, 6'd7, 32'h0, 0, 6'd7, 6'd30);
        step();
        disp(4'h4, 32'h11, 1, 6'd7, 32'h0, 0, 6'd7, 6'd31);
        step();
        idle();
        cdb(6'd7, 32'h33);
        step();
        idle();
        n_checks++; if (bus.issue_rdtag !== 6'd30 || bus.issue_rsdata !== 32'h33 || bus.issue_rtdata !== 32'h33)
            begin n_fail++; $display("FAIL wb_both: got rd=%0d rs=%h rt=%h want 30 33 33", bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.issue_rdtag !== 6'd31 || bus.issue_rsdata !== 32'h11 || bus.issue_rtdata !== 32'h33)
            begin n_fail++; $display("FAIL wb_keep_valid: got rd=%0d rs=%h rt=%h want 31 11 33", bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.queue_count !== 4'd0) begin n_fail++; $display("FAIL wb_drain: got %0d want 0", bus.queue_count); end
    endtask

    task automatic test_bypass();
        disp(4'h5, 32'h0, 0, 6'd3, 32'h2, 1, 0, 6'd5);
        cdb(6'd3, 32'hA5);
        step();
        idle();
        n_checks++; if (bus.ready_int !== 1'b1 || bus.issue_rsdata !== 32'hA5 || bus.issue_rdtag !== 6'd5)
            begin n_fail++; $display("FAIL bp_capture: got ready=%b rs=%h rd=%0d want 1 a5 5", bus.ready_int, bus.issue_rsdata, bus.issue_rdtag); end
        bus.issue_int = 1;
        step();
        idle();
    endtask

    task automatic test_age_full_simul();
        disp(4'h1, 32'hA, 1, 0, 32'hB, 1, 0, 6'd10);
        step();
        disp(4'h1, 32'h0, 0, 6'd40, 32'hC, 1, 0, 6'd11);
        step();
        disp(4'h1, 32'hD, 1, 0, 32'hE, 1, 0, 6'd12);
        step();
        disp(4'h1, 32'hF, 1, 0, 32'h0, 0, 6'd41, 6'd13);
        step();
        idle();
        n_checks++; if (bus.queue_full !== 1'b1 || bus.queue_count !== 4'd4) begin n_fail++; $display("FAIL ag_full: got full=%b count=%0d want 1 4", bus.queue_full, bus.queue_count); end
        n_checks++; if (bus.issue_rdtag !== 6'd10) begin n_fail++; $display("FAIL ag_oldest: got %0d want 10", bus.issue_rdtag); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.queue_full !== 1'b0 || bus.queue_count !== 4'd3) begin n_fail++; $display("FAIL ag_collapse: got full=%b count=%0d want 0 3", bus.queue_full, bus.queue_count); end
        n_checks++; if (bus.issue_rdtag !== 6'd12) begin n_fail++; $display("FAIL ag_next: got %0d want 12", bus.issue_rdtag); end
        disp(4'h1, 32'h1, 1, 0, 32'h1, 1, 0, 6'd14);
        step();
        idle();
        n_checks++; if (bus.queue_full !== 1'b1) begin n_fail++; $display("FAIL fb_refill: got %b want 1", bus.queue_full); end
        disp(4'h1, 32'h2, 1, 0, 32'h2, 1, 0, 6'd15);
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.queue_count !== 4'd3) begin n_fail++; $display("FAIL fb_dropped: got count=%0d want 3", bus.queue_count); end
        n_checks++; if (bus.issue_rdtag !== 6'd14) begin n_fail++; $display("FAIL fb_order: got %0d want 14", bus.issue_rdtag); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.ready_int !== 1'b0 || bus.queue_count !== 4'd2) begin n_fail++; $display("FAIL fb_pending: got ready=%b count=%0d want 0 2", bus.ready_int, bus.queue_count); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.queue_count !== 4'd2) begin n_fail++; $display("FAIL ig_no_ready: got %0d want 2", bus.queue_count); end
        cdb(6'd41, 32'h99);
        step();
        idle();
        n_checks++; if (bus.issue_rdtag !== 6'd13 || bus.issue_rtdata !== 32'h99) begin n_fail++; $display("FAIL ag_wake13: got rd=%0d rt=%h want 13 99", bus.issue_rdtag, bus.issue_rtdata); end
        disp(4'h6, 32'h6, 1, 0, 32'h6, 1, 0, 6'd16);
        cdb(6'd40, 32'h77);
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.queue_count !== 4'd2) begin n_fail++; $display("FAIL sm_count: got %0d want 2", bus.queue_count); end
        n_checks++; if (bus.issue_rdtag !== 6'd11 || bus.issue_rsdata !== 32'h77 || bus.issue_rtdata !== 32'hC)
            begin n_fail++; $display("FAIL sm_head: got rd=%0d rs=%h rt=%h want 11 77 c", bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.issue_rdtag !== 6'd16 || bus.issue_opcode !== 4'h6) begin n_fail++; $display("FAIL sm_tail: got rd=%0d op=%h want 16 6", bus.issue_rdtag, bus.issue_opcode); end
        bus.issue_int = 1;
        step();
        idle();
        n_checks++; if (bus.queue_count !== 4'd0 || bus.ready_int !== 1'b0) begin n_fail++; $display("FAIL sm_empty: got count=%0d ready=%b want 0 0", bus.queue_count, bus.ready_int); end
    endtask

    task automatic fill_three();
        disp(4'h1, 32'h0, 0, 6'd50, 32'h1, 1, 0, 6'd20);
        step();
        disp(4'h2, 32'h2, 1, 0, 32'h3, 1, 0, 6'd21);
        step();
        disp(4'h3, 32'h4, 1, 0, 32'h0, 0, 6'd51, 6'd22);
        step();
        idle();
    endtask

    task automatic test_flush();
        fill_three();
        n_checks++; if (bus.queue_count !== 4'd3 || bus.issue_rdtag !== 6'd21) begin n_fail++; $display("FAIL fl_pre: got count=%0d rd=%0d want 3 21", bus.queue_count, bus.issue_rdtag); end
        disp(4'h7, 32'h8, 1, 0, 32'h9, 1, 0, 6'd23);
        cdb(6'd50, 32'h55);
        bus.issue_int = 1;
        bus.flush = 1;
        step();
        idle();
        n_checks++; if (bus.queue_count !== 4'd0 || bus.ready_int !== 1'b0 || bus.queue_full !== 1'b0)
            begin n_fail++; $display("FAIL fl_state: got count=%0d ready=%b full=%b want 0 0 0", bus.queue_count, bus.ready_int, bus.queue_full); end
        n_checks++; if (bus.issue_rsdata !== 32'h0 || bus.issue_rtdata !== 32'h0 || bus.issue_rdtag !== 6'h0 || bus.issue_opcode !== 4'h0)
            begin n_fail++; $display("FAIL fl_issue: got op=%h rs=%h rt=%h rd=%h want all 0", bus.issue_opcode, bus.issue_rsdata, bus.issue_rtdata, bus.issue_rdtag); end
        cdb(6'd51, 32'h66);
        step();
        idle();
        n_checks++; if (bus.ready_int !== 1'b0) begin n_fail++; $display("FAIL fl_stale_wake: got %b want 0", bus.ready_int); end
    endtask

    task automatic test_reset_mid();
        fill_three();
        disp(4'h7, 32'h8, 1, 0, 32'h9, 1, 0, 6'd23);
        bus.issue_int = 1;
        reset = 1;
        step();
        reset = 0;
        idle();
        n_checks++; if (bus.queue_count !== 4'd0 || bus.ready_int !== 1'b0 || bus.queue_full !== 1'b0)
            begin n_fail++; $display("FAIL rm_state: got count=%0d ready=%b full=%b want 0 0 0", bus.queue_count, bus.ready_int, bus.queue_full); end
        n_checks++; if (bus.issue_rsdata !== 32'h0 || bus.issue_rdtag !== 6'h0 || bus.issue_opcode !== 4'h0)
            begin n_fail++; $display("FAIL rm_issue: got op=%h rs=%h rd=%h want all 0", bus.issue_opcode, bus.issue_rsdata, bus.issue_rdtag); end
        disp(4'h9, 32'h42, 1, 0, 32'h43, 1, 0, 6'd44);
        step();
        idle();
        n_checks++; if (bus.issue_rdtag !== 6'd44 || bus.queue_count !== 4'd1) begin n_fail++; $display("FAIL rm_reuse: got rd=%0d count=%0d want 44 1", bus.issue_rdtag, bus.queue_count); end
    endtask

    initial begin
        idle();
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_wakeup_both();
        test_bypass();
        test_age_full_simul();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer reservation-station queue feeding the integer path of the issue unit.
- Accepts dispatched ops with operand values or pending producer tags.
- Snoops the CDB (cdb_valid/tag/data) to wake pending operands.
- Presents the oldest fully-ready op as ready_int and retires it when the issue unit answers with issue_int. This is the consumer end of the CDB and the requester end of the ready/issue handshake.

Parameters:
DEPTH, 4, number of queue entries (2..8)
TAG_W, 6, rob/rename tag width
DATA_W, 32, operand width

Ports:
clk  input  1  clock
reset  input  1  reset
dispatch_en  input  1  write new op this cycle
dispatch_opcode  input  4  ALU opcode
dispatch_rsdata  input  DATA_W  rs value (valid when dispatch_rsvalid)
dispatch_rsvalid  input  1  rs value present
dispatch_rstag  input  TAG_W  rs producer tag when not valid
dispatch_rtdata  input  DATA_W  rt value
dispatch_rtvalid  input  1  rt value present
dispatch_rttag  input  TAG_W  rt producer tag
dispatch_rdtag  input  TAG_W  destination tag
queue_full  output  1  no free entry
queue_count  output  4  occupied entries
cdb_valid  input  1  CDB broadcast valid
cdb_tagout  input  TAG_W  CDB broadcast tag
cdb_out  input  DATA_W  CDB broadcast data
flush  input  1  discard all entries (mispredict)
ready_int  output  1  an entry is ready to issue
issue_int  input  1  grant from issue unit
issue_opcode  output  4  selected op
issue_rsdata  output  DATA_W  selected rs
issue_rtdata  output  DATA_W  selected rt
issue_rdtag  output  TAG_W  selected rd tag

Behaviour:
- Single clock clk. reset is synchronous and active-high.
- Reset: all entries invalid. ready_int=0, queue_full=0, queue_count=0. All issue_* outputs =0.
- Storage is a collapsing queue: index 0 is the oldest. Each entry holds:
  - valid
  - opcode
  - rs value / rs valid / rs tag
  - rt value / rt valid / rt tag
  - rdtag
- An entry is ready when valid & rsvalid & rtvalid.
- Select logic: the lowest-index ready entry is selected.
  - ready_int and issue_* are combinational from registered state only. There is no path from issue_int or the CDB inputs to them.
  - When no entry is ready, issue_* are 0.
- Grant: issue_int=1 while ready_int=1 removes the selected entry at the clock edge. Entries above it shift down one index in the same edge, preserving age order.
  - issue_int while ready_int=0 is ignored.
  - One issue per cycle max.
- Wakeup: on cdb_valid=1, every valid entry with a pending operand whose tag equals cdb_tagout captures cdb_out and sets that operand valid at the edge.
  - The entry may become ready the next cycle, giving a one-cycle wakeup-to-ready latency.
  - Both operands of the same entry may wake on the same broadcast.
  - Already-valid operands ignore tag matches.
- Dispatch: dispatch_en=1 with queue_full=0 writes at index queue_count, or queue_count-1 if an issue grant fires the same cycle.
  - Dispatch CDB bypass: if an operand is not valid and its tag equals cdb_tagout with cdb_valid=1 in the same cycle, cdb_out is written and the operand is marked valid.
- Full: queue_full = (queue_count==DEPTH), registered-state derived.
  - Dispatch while queue_full=1 is dropped, even if a grant frees a slot that same cycle. The dispatcher must hold the op.
- Simultaneous events:
  - Issue + dispatch + wakeup all apply in one edge. The shifted entries keep any wakeup captured that edge.
  - queue_count changes by +1, -1, or 0 accordingly.
- Flush: at the edge, all entries are invalidated and queue_count=0. Flush overrides dispatch, wakeup and grant that cycle.
- Reset mid-operation behaves identically to flush and also zeroes all stored fields.

Test Plan:
- Ready dispatch and issue: reset, then dispatch opcode=4'h2, rs=32'h5 valid, rt=32'h7 valid, rd=6'd9 → next cycle ready_int=1, issue_rsdata=5, issue_rtdata=7, issue_rdtag=9. Assert issue_int=1 one cycle → next cycle ready_int=0, queue_count=0.
- CDB wakeup: dispatch with rs pending tag 6'd12, rt=32'h1 valid → ready_int=0. Broadcast cdb_valid=1, tag=12, data=32'hDEAD → next cycle ready_int=1, issue_rsdata=32'hDEAD.
- Dispatch bypass: dispatch rs pending tag 6'd3 in the same cycle as CDB tag=3, data=32'hA5 → next cycle entry ready, rsdata=32'hA5.
- Age order and collapse: fill 4 entries; entries 0 and 2 ready, rd=10 and 12 → issue presents rd=10 first. After grant queue_full=0, queue_count=3, and next issue_rdtag=12.
- Full boundary: with queue_count=4, dispatch_en=1 plus issue_int=1 → dispatch dropped, queue_count=3, the dispatched rdtag is never issued.
- Flush and reset: 3 entries valid with one ready, assert flush together with dispatch_en and issue_int → next cycle queue_count=0, ready_int=0, issue_*=0. Repeat with reset → same, and queue_full=0.
